// File: rtl/huffman_tree_builder.sv
// rtl/huffman_tree_builder.sv - builds the 2-D canonical Huffman lookup tree in the decoder tree RAM
module huffman_tree_builder #(
  parameter int NUMCODES = 288,
  parameter int OUTWIDTH = 10,
  parameter int MAXLEN   = 15,
  localparam int AW = $clog2(2*NUMCODES),
  localparam int NW = $clog2(NUMCODES+1)
) (
  input  logic                rstn,
  input  logic                clk,
  input  logic                istart,
  input  logic [NW-1:0]       inum,
  input  logic                ien,
  input  logic [3:0]          ilen,
  output logic                obusy,
  output logic                odone,
  output logic                oerr,
  output logic                wen,
  output logic [AW-1:0]       waddr,
  output logic [OUTWIDTH-1:0] wdata,
  output logic [AW-1:0]       raddr,
  input  logic [OUTWIDTH-1:0] rdata
);

  localparam int TW = AW - 1;
  localparam logic [OUTWIDTH-1:0] UNSET   = '1;
  localparam logic [OUTWIDTH-1:0] NC_WORD = OUTWIDTH'(NUMCODES);
  localparam logic [AW-1:0]       CLR_END = AW'(2*NUMCODES);
  localparam logic [NW-1:0]       NF_MAX  = NW'(NUMCODES-2);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_NEXTCODE, S_FETCH, S_RD, S_CHK, S_DONE
  } state_t;

  state_t              state_q;
  logic [NW-1:0]       inum_q, sym_q, nf_q;
  logic [AW-1:0]       clr_q;
  logic [3:0]          lcnt_q, bidx_q;
  logic [15:0]         code_q, c_q;
  logic [TW-1:0]       tpos_q;
  logic [NW-1:0]       bl_count_q [0:MAXLEN];
  logic [15:0]         next_code_q [0:MAXLEN];
  logic [3:0]          len_mem [0:NUMCODES-1];
  logic                obusy_q, odone_q, oerr_q;

  logic                clr_done, intake_done, last_bit;
  logic                rd_unset, rd_node, nf_full;
  logic [3:0]          cur_len;
  logic [AW-1:0]       cur_addr;
  logic [NW-1:0]       nf_inc;
  logic [OUTWIDTH-1:0] node_word, node_off;
  logic [NW-1:0]       bl_prev;
  logic [15:0]         nc_sum, nc_val;

  assign obusy = obusy_q;
  assign odone = odone_q;
  assign oerr  = oerr_q;

  // Shared decode of the current tree walk step and the next_code recurrence
  always_comb begin
    clr_done    = (clr_q == CLR_END);
    intake_done = (sym_q == inum_q);
    cur_len     = len_mem[sym_q];
    cur_addr    = {tpos_q, c_q[bidx_q]};
    last_bit    = (bidx_q == 4'd0);
    rd_unset    = (rdata == UNSET);
    rd_node     = (rdata >= NC_WORD);
    nf_full     = (nf_q >= NF_MAX);
    nf_inc      = nf_q + NW'(1);
    node_word   = NC_WORD + OUTWIDTH'(nf_inc);
    node_off    = rdata - NC_WORD;
    bl_prev     = (lcnt_q == 4'd1) ? '0 : bl_count_q[lcnt_q - 4'd1];
    nc_sum      = code_q + 16'(bl_prev);
    nc_val      = nc_sum << 1;
  end

  // Tree RAM ports: clear sweep during LOAD, single leaf/node write in CHK, read only in RD
  always_comb begin
    wen   = 1'b0;
    waddr = '0;
    wdata = '0;
    raddr = (state_q == S_RD) ? cur_addr : '0;
    if (state_q == S_LOAD && !clr_done) begin
      wen   = 1'b1;
      waddr = clr_q;
      wdata = UNSET;
    end else if (state_q == S_CHK) begin
      if (last_bit) begin
        if (rd_unset) begin
          wen   = 1'b1;
          waddr = cur_addr;
          wdata = OUTWIDTH'(sym_q);
        end
      end else if (rd_unset && !nf_full) begin
        wen   = 1'b1;
        waddr = cur_addr;
        wdata = node_word;
      end
    end
  end

  // Per-symbol code length store, written during intake
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD && !istart && ien && !intake_done) begin
      len_mem[sym_q] <= ilen;
    end
  end

  // Build sequencer: LOAD -> NEXTCODE -> FETCH/RD/CHK per symbol -> DONE
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      inum_q  <= '0;
      sym_q   <= '0;
      nf_q    <= '0;
      clr_q   <= '0;
      lcnt_q  <= '0;
      bidx_q  <= '0;
      code_q  <= '0;
      c_q     <= '0;
      tpos_q  <= '0;
      obusy_q <= 1'b0;
      odone_q <= 1'b0;
      oerr_q  <= 1'b0;
      for (int l = 0; l <= MAXLEN; l++) begin
        bl_count_q[l]  <= '0;
        next_code_q[l] <= '0;
      end
    end else if (istart) begin
      state_q <= S_LOAD;
      inum_q  <= inum;
      sym_q   <= '0;
      nf_q    <= '0;
      clr_q   <= '0;
      obusy_q <= 1'b1;
      odone_q <= 1'b0;
      oerr_q  <= 1'b0;
      for (int l = 0; l <= MAXLEN; l++) begin
        bl_count_q[l] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          odone_q <= 1'b0;
        end
        S_LOAD: begin
          if (!clr_done) clr_q <= clr_q + AW'(1);
          if (ien && !intake_done) begin
            if (ilen != 4'd0) bl_count_q[ilen] <= bl_count_q[ilen] + NW'(1);
            sym_q <= sym_q + NW'(1);
          end
          if (clr_done && intake_done) begin
            state_q <= S_NEXTCODE;
            lcnt_q  <= 4'd1;
            code_q  <= '0;
            sym_q   <= '0;
          end
        end
        S_NEXTCODE: begin
          code_q              <= nc_val;
          next_code_q[lcnt_q] <= nc_val;
          lcnt_q              <= lcnt_q + 4'd1;
          if (lcnt_q == 4'(MAXLEN)) state_q <= S_FETCH;
        end
        S_FETCH: begin
          if (intake_done) begin
            state_q <= S_DONE;
            obusy_q <= 1'b0;
            odone_q <= 1'b1;
          end else if (cur_len == 4'd0) begin
            sym_q <= sym_q + NW'(1);
          end else begin
            c_q                  <= next_code_q[cur_len];
            next_code_q[cur_len] <= next_code_q[cur_len] + 16'd1;
            bidx_q               <= cur_len - 4'd1;
            tpos_q               <= '0;
            state_q              <= S_RD;
          end
        end
        S_RD: begin
          state_q <= S_CHK;
        end
        S_CHK: begin
          if (last_bit && rd_unset) begin
            sym_q   <= sym_q + NW'(1);
            state_q <= S_FETCH;
          end else if (!last_bit && rd_unset && !nf_full) begin
            nf_q    <= nf_inc;
            tpos_q  <= TW'(nf_inc);
            bidx_q  <= bidx_q - 4'd1;
            state_q <= S_RD;
          end else if (!last_bit && !rd_unset && rd_node) begin
            tpos_q  <= TW'(node_off);
            bidx_q  <= bidx_q - 4'd1;
            state_q <= S_RD;
          end else begin
            oerr_q  <= 1'b1;
            obusy_q <= 1'b0;
            odone_q <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          odone_q <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
